// File: rtl/core_pkg.sv
// Shared types and constants for the multi-cycle RV32I sequencer.
// State encoding, decoder flag indices and trap cause codes.
package core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_RESOLVE,
    ST_WB,
    ST_TRAP
  } state_t;

  localparam int BEQ_BIT  = 27;
  localparam int BNE_BIT  = 28;
  localparam int BLT_BIT  = 29;
  localparam int BGE_BIT  = 30;
  localparam int BLTU_BIT = 31;
  localparam int BGEU_BIT = 32;
  localparam int JAL_BIT  = 33;
  localparam int JALR_BIT = 34;

  localparam logic [1:0] TRAP_NONE     = 2'd0;
  localparam logic [1:0] TRAP_MISALIGN = 2'd1;
  localparam logic [1:0] TRAP_ALU_TO   = 2'd2;

  function automatic logic is_cond_branch(
    input logic [36:0] bus
  );
    return bus[BEQ_BIT]  | bus[BNE_BIT]  |
           bus[BLT_BIT]  | bus[BGE_BIT]  |
           bus[BLTU_BIT] | bus[BGEU_BIT];
  endfunction

endpackage

// File: rtl/core_sequencer_alu_watchdog.sv
// Counts EXEC cycles spent waiting on the ALU.
// expired fires on the last allowed waiting cycle.
module alu_watchdog #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/exec/resolve/writeback sequencer.
// Owns the architectural PC and a sticky trap.
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          PC_STEP     = 4,
  parameter int          ALU_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  input  logic [36:0] instr_bus,
  output logic        rf_read,
  output logic        alu_start,
  input  logic        alu_ready,
  input  logic        rd_valid,
  output logic        branch_eval,
  input  logic        pc_j_valid,
  input  logic [31:0] next_pc,
  output logic        rd_write,
  output logic [31:0] pc,
  output logic        retire,
  input  logic        halt,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [1:0]  cause_q, cause_d;
  logic trap_q, trap_d;
  logic req_q, req_d;
  logic rf_q, rf_d;
  logic start_q, start_d;
  logic beval_q, beval_d;
  logic rdw_q, rdw_d;
  logic ret_q, ret_d;

  logic is_br;
  logic wd_clr;
  logic wd_en;
  logic wd_expired;
  logic unused_bus;

  assign is_br = is_cond_branch(instr_bus);
  assign unused_bus = ^{instr_bus[JAL_BIT],
                        instr_bus[JALR_BIT],
                        instr_bus};

  assign wd_clr = (state_q != ST_EXEC);
  assign wd_en  = (state_q == ST_EXEC) &&
                  !is_br && !alu_ready;

  alu_watchdog #(
    .LIMIT (ALU_TIMEOUT)
  ) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cause_d = cause_q;
    rdw_d   = 1'b0;
    ret_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!halt) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // ack only counts once the request is visible
        if (req_q && imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_br || alu_ready) begin
          state_d = ST_RESOLVE;
        end else if (wd_expired) begin
          state_d = ST_TRAP;
          cause_d = TRAP_ALU_TO;
        end
      end
      ST_RESOLVE: begin
        state_d = ST_WB;
      end
      ST_WB: begin
        if (pc_j_valid && (next_pc[1:0] != 2'b00)) begin
          state_d = ST_TRAP;
          cause_d = TRAP_MISALIGN;
        end else begin
          ret_d   = 1'b1;
          rdw_d   = rd_valid && !is_br;
          pc_d    = pc_j_valid ? next_pc
                               : pc_q + 32'(PC_STEP);
          state_d = halt ? ST_IDLE : ST_FETCH;
        end
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_TRAP;
      end
    endcase
    req_d   = (state_d == ST_FETCH);
    rf_d    = (state_d == ST_DECODE);
    start_d = (state_q == ST_DECODE) && !is_br;
    beval_d = (state_d == ST_RESOLVE);
    trap_d  = (state_d == ST_TRAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cause_q <= TRAP_NONE;
      trap_q  <= 1'b0;
      req_q   <= 1'b0;
      rf_q    <= 1'b0;
      start_q <= 1'b0;
      beval_q <= 1'b0;
      rdw_q   <= 1'b0;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cause_q <= cause_d;
      trap_q  <= trap_d;
      req_q   <= req_d;
      rf_q    <= rf_d;
      start_q <= start_d;
      beval_q <= beval_d;
      rdw_q   <= rdw_d;
      ret_q   <= ret_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign rf_read     = rf_q;
  assign alu_start   = start_q;
  assign branch_eval = beval_q;
  assign rd_write    = rdw_q;
  assign pc          = pc_q;
  assign retire      = ret_q;
  assign trap        = trap_q;
  assign trap_cause  = cause_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer.
// Hand-computed expectations sampled 1 ns after each rising edge.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic [36:0] instr_bus = '0;
  logic        rf_read;
  logic        alu_start;
  logic        alu_ready = 1'b0;
  logic        rd_valid = 1'b0;
  logic        branch_eval;
  logic        pc_j_valid = 1'b0;
  logic [31:0] next_pc = '0;
  logic        rd_write;
  logic [31:0] pc;
  logic        retire;
  logic        halt = 1'b0;
  logic        trap;
  logic [1:0]  trap_cause;

  int nvec = 0;
  int nerr = 0;

  localparam logic [36:0] B_ADDI = 37'h1;
  localparam logic [36:0] B_BEQ  = 37'h1 << 27;
  localparam logic [36:0] B_JAL  = 37'h1 << 33;
  localparam logic [36:0] B_JALR = 37'h1 << 34;

  core_sequencer #(
    .RESET_PC    (32'h0000_0000),
    .PC_STEP     (4),
    .ALU_TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_bus   (instr_bus),
    .rf_read     (rf_read),
    .alu_start   (alu_start),
    .alu_ready   (alu_ready),
    .rd_valid    (rd_valid),
    .branch_eval (branch_eval),
    .pc_j_valid  (pc_j_valid),
    .next_pc     (next_pc),
    .rd_write    (rd_write),
    .pc          (pc),
    .retire      (retire),
    .halt        (halt),
    .trap        (trap),
    .trap_cause  (trap_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: sim time limit hit");
    $fatal(1, "time limit");
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobes_zero(input string tag);
    chk({tag, ".req"}, 32'(imem_req), 0);
    chk({tag, ".rf"}, 32'(rf_read), 0);
    chk({tag, ".start"}, 32'(alu_start), 0);
    chk({tag, ".beval"}, 32'(branch_eval), 0);
    chk({tag, ".rdw"}, 32'(rd_write), 0);
    chk({tag, ".ret"}, 32'(retire), 0);
  endtask

  // Entered in FETCH with imem_req high; returns one cycle after WB.
  task automatic run_op(
    input string       tag,
    input logic [31:0] word,
    input logic [36:0] bus,
    input logic        exp_start,
    input int          alu_wait,
    input logic        rdv,
    input logic        jv,
    input logic [31:0] npc,
    input logic        hlt
  );
    chk({tag, ".req"}, 32'(imem_req), 1);
    imem_ack   = 1'b1;
    imem_rdata = word;
    instr_bus  = bus;
    rd_valid   = rdv;
    step();
    imem_ack = 1'b0;
    chk({tag, ".rf"}, 32'(rf_read), 1);
    chk({tag, ".instr"}, instr, word);
    chk({tag, ".req_off"}, 32'(imem_req), 0);
    step();
    chk({tag, ".start"}, 32'(alu_start), 32'(exp_start));
    halt = hlt;
    if (exp_start) begin
      repeat (alu_wait) step();
      alu_ready = 1'b1;
      step();
      alu_ready = 1'b0;
    end else begin
      step();
    end
    chk({tag, ".beval"}, 32'(branch_eval), 1);
    pc_j_valid = jv;
    next_pc    = npc;
    step();
    chk({tag, ".ret_wb"}, 32'(retire), 0);
    step();
    pc_j_valid = 1'b0;
  endtask

  initial begin
    #2;
    strobes_zero("rst");
    chk("rst.pc", pc, 32'h0);
    chk("rst.trap", 32'(trap), 0);
    chk("rst.cause", 32'(trap_cause), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("f0.req", 32'(imem_req), 1);
    chk("f0.addr", imem_addr, 32'h0);
    step();

    run_op("addi", 32'h0010_0093, B_ADDI, 1'b1, 1,
           1'b1, 1'b0, 32'h0, 1'b0);
    chk("addi.ret", 32'(retire), 1);
    chk("addi.rdw", 32'(rd_write), 1);
    chk("addi.pc", pc, 32'h4);
    chk("addi.addr", imem_addr, 32'h4);
    chk("addi.req", 32'(imem_req), 1);
    step();
    chk("addi.ret1", 32'(retire), 0);
    chk("addi.rdw1", 32'(rd_write), 0);

    run_op("jal", 32'h0100_006f, B_JAL, 1'b1, 0,
           1'b1, 1'b1, 32'h10, 1'b0);
    chk("jal.pc", pc, 32'h10);
    chk("jal.rdw", 32'(rd_write), 1);

    run_op("beq", 32'hfe00_0ce3, B_BEQ, 1'b0, 0,
           1'b1, 1'b1, 32'h8, 1'b0);
    chk("beq.pc", pc, 32'h8);
    chk("beq.rdw", 32'(rd_write), 0);
    chk("beq.ret", 32'(retire), 1);

    run_op("jalr", 32'h0000_80e7, B_JALR, 1'b1, 2,
           1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    chk("jalr.pc", pc, 32'hFFFF_FFFC);
    run_op("wrap", 32'h0000_0013, B_ADDI, 1'b1, 0,
           1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap.pc", pc, 32'h0);
    chk("wrap.rdw", 32'(rd_write), 0);

    run_op("halt", 32'h0000_0013, B_ADDI, 1'b1, 1,
           1'b1, 1'b0, 32'h0, 1'b1);
    chk("halt.ret", 32'(retire), 1);
    chk("halt.req", 32'(imem_req), 0);
    chk("halt.pc", pc, 32'h4);
    step();
    step();
    chk("idle.req", 32'(imem_req), 0);
    halt = 1'b0;
    step();
    chk("resume.req", 32'(imem_req), 1);
    chk("resume.addr", imem_addr, 32'h4);

    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0033;
    instr_bus  = B_ADDI;
    step();
    imem_ack = 1'b0;
    step();
    chk("to.start", 32'(alu_start), 1);
    repeat (15) step();
    chk("to.trap15", 32'(trap), 0);
    step();
    chk("to.trap16", 32'(trap), 1);
    chk("to.cause", 32'(trap_cause), 2);
    chk("to.pc", pc, 32'h4);
    step();
    chk("to.req", 32'(imem_req), 0);

    rst_n = 1'b0;
    #1;
    chk("rtrap.trap", 32'(trap), 0);
    chk("rtrap.cause", 32'(trap_cause), 0);
    chk("rtrap.pc", pc, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("rf.req", 32'(imem_req), 1);
    rst_n = 1'b0;
    #1;
    strobes_zero("rfetch");
    step();
    rst_n = 1'b1;
    step();
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0013;
    instr_bus  = B_ADDI;
    step();
    imem_ack = 1'b0;
    step();
    chk("rx.start", 32'(alu_start), 1);
    rst_n = 1'b0;
    #1;
    strobes_zero("rexec");
    chk("rexec.pc", pc, 32'h0);
    chk("rexec.instr", instr, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    run_op("pre", 32'h0000_0013, B_ADDI, 1'b1, 0,
           1'b1, 1'b0, 32'h0, 1'b0);
    chk("pre.pc", pc, 32'h4);
    run_op("mis", 32'h1020_006f, B_JAL, 1'b1, 0,
           1'b1, 1'b1, 32'h102, 1'b0);
    chk("mis.trap", 32'(trap), 1);
    chk("mis.cause", 32'(trap_cause), 1);
    chk("mis.pc", pc, 32'h4);
    chk("mis.ret", 32'(retire), 0);
    chk("mis.rdw", 32'(rd_write), 0);
    chk("mis.req", 32'(imem_req), 0);
    repeat (3) step();
    chk("mis.req3", 32'(imem_req), 0);
    chk("mis.trap3", 32'(trap), 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multi-cycle sequencer for the single-issue RV32I core.
- Drives instruction fetch, register-file read, ALU start, branch/jump resolution strobe, rd writeback enable and PC update, in that order, for one instruction at a time.
- Sits between the instruction memory port, the decoder (37-bit instr_bus), the ALU and the branch/writeback control unit.
- Owns the architectural PC and raises a sticky trap on a misaligned jump target or an ALU hang.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, sequential PC increment
ALU_TIMEOUT, 16, max cycles in EXEC waiting for alu_ready before trap (range 2..255)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  32  fetch address (= pc)
imem_ack  in  1  fetch complete, imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction word
instr  out  32  latched instruction to decoder
instr_bus  in  37  decoded one-hot instruction flags; bits 27..32 = beq,bne,blt,bge,bltu,bgeu; 33 = jal; 34 = jalr
rf_read  out  1  register-file read enable (DECODE cycle)
alu_start  out  1  one-cycle ALU launch pulse
alu_ready  in  1  ALU result valid
rd_valid  in  1  decoded instruction writes rd
branch_eval  out  1  one-cycle strobe: control unit evaluates branch/jump
pc_j_valid  in  1  control unit: redirect taken (registered, valid cycle after branch_eval)
next_pc  in  32  redirect target
rd_write  out  1  writeback enable pulse
pc  out  32  architectural PC
retire  out  1  one-cycle pulse per completed instruction
halt  in  1  stop after current instruction retires
trap  out  1  sticky trap flag
trap_cause  out  2  0 none, 1 misaligned target, 2 ALU timeout

Behaviour:
- Reset (rst_n low, async, any state): state=FETCH, pc=RESET_PC, instr=0, trap=0, trap_cause=0, watchdog=0. All strobes (imem_req, rf_read, alu_start, branch_eval, rd_write, retire) =0 immediately. An in-flight fetch is abandoned.
- States: IDLE, FETCH, DECODE, EXEC, RESOLVE, WB, TRAP.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: latch instr<=imem_rdata, go to DECODE.
  - Ack in any other state is ignored.
- DECODE (1 cycle): rf_read=1, go to EXEC.
- EXEC:
  - Conditional branch (any of instr_bus[32:27]): no ALU use; go to RESOLVE next cycle.
  - Otherwise: alu_start=1 on the first EXEC cycle only, watchdog counts. On alu_ready, go to RESOLVE.
  - alu_ready on the same cycle as alu_start is accepted (zero-wait ALU).
  - Watchdog reaching ALU_TIMEOUT without alu_ready: trap_cause=2, go to TRAP.
- RESOLVE (1 cycle): branch_eval=1, go to WB.
- WB (1 cycle):
  - retire=1.
  - rd_write=rd_valid AND NOT a conditional branch.
  - If pc_j_valid=1 and next_pc[1:0]==0: pc<=next_pc.
  - If pc_j_valid=1 and next_pc[1:0]!=0: pc unchanged, retire=0, rd_write=0, trap_cause=1, go to TRAP.
  - If pc_j_valid=0: pc<=pc+PC_STEP, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  - Next state: IDLE if halt=1, else FETCH.
- IDLE: all strobes 0; return to FETCH when halt=0.
- TRAP: terminal until reset. trap=1, strobes 0, pc frozen.
- Per-instruction latency: fetch wait + 4 cycles (branch), or fetch wait + ALU latency + 3 cycles (ALU op).
- Outputs are registered except imem_addr (=pc).

Decomposition:
- Shared package core_pkg:
  - state encoding
  - instr_bus bit indices BEQ_BIT=27 .. JALR_BIT=34
  - TRAP_NONE/TRAP_MISALIGN/TRAP_ALU_TO codes
- One sub-module: alu_watchdog (clear/enable/expired counter, width $clog2(ALU_TIMEOUT+1)).

Test Plan:
- Reset, then an addi with imem_ack 2 cycles after req and alu_ready 1 cycle after alu_start -> imem_addr=0; rd_write and retire pulse once; pc=4; FETCH at addr 4.
- beq taken, pc=0x10, next_pc=0x8, pc_j_valid=1 -> no alu_start; rd_write=0; pc=0x8.
- jal with next_pc=0x102 -> trap=1, trap_cause=1, pc stays, no retire, no further imem_req.
- alu_ready never asserted, ALU_TIMEOUT=16 -> trap_cause=2 exactly 16 cycles after alu_start.
- pc=32'hFFFF_FFFC, non-branch -> pc wraps to 0. Separately, halt=1 during EXEC -> instruction retires, then IDLE; halt released -> FETCH resumes.
- rst_n low mid-EXEC and mid-FETCH -> all strobes 0 the same cycle; pc=RESET_PC; trap cleared.
